gray_decoder_serial: RTL
========================

// Module: gray_decoder_serial
// PURPOSE
//  Sequential Gray-to-binary decoder: the inverse of the Binary Codes Gray encoder.
//  - Accepts one WIDTH-bit Gray word over a valid/ready handshake.
//  - Decodes it MSB-first, one bit per clock, using a running XOR.
//  - Presents the binary result over a second valid/ready handshake.
//  - Flags an adjacency error when consecutive accepted words differ in more than one bit.
// PARAMETERS
//  WIDTH   4   Gray/binary word width in bits (>= 2)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      gray_in is valid
//  in_ready   out  1      block can accept a word
//  gray_in    in   WIDTH  Gray-coded input word
//  out_valid  out  1      bin_out/adj_err are valid
//  out_ready  in   1      consumer takes the result
//  bin_out    out  WIDTH  decoded binary word
//  adj_err    out  1      Hamming distance to previous accepted word > 1
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge):
//    - state=IDLE; bin_out=0; out_valid=0; adj_err=0; prev_valid=0; bit index cleared.
//    - in_ready=0 while rst_n is low.
//    - Reset mid-decode or in HOLD discards the partial or held word.
//  - FSM IDLE -> DECODE -> HOLD -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&in_ready, capture gray_in into g_reg and set idx=WIDTH-1.
//    - Compute adj_err = prev_valid && popcount(gray_in^prev_gray)>1.
//    - Set prev_gray=gray_in and prev_valid=1, then go to DECODE.
//  - DECODE:
//    - in_ready=0; gray_in changes are ignored.
//    - Each cycle: b[idx] = (idx==WIDTH-1) ? g[idx] : b[idx+1]^g[idx]; then decrement idx.
//    - After the cycle with idx==0, go to HOLD.
//  - HOLD:
//    - out_valid=1; bin_out and adj_err stay stable until out_ready is sampled high.
//    - On out_valid&out_ready, clear out_valid and return to IDLE on the same edge.
//  - Latency: out_valid rises exactly WIDTH clocks after the accept edge (4 for default WIDTH).
//  - Throughput: at most one word per WIDTH+2 clocks. in_ready is never high in DECODE or HOLD.
//  - bin_out is registered and may show partial bits during DECODE. It is only meaningful while out_valid=1.
//  - Adjacency rules:
//    - A repeated identical word (distance 0) is not an error.
//    - The first word after reset never flags.
//    - Wrap-around, e.g. 1000->0000 for WIDTH=4, is distance 1 and is legal.
//    - adj_err does not stall decoding. The word is still decoded and delivered.
//  - Simultaneous in_valid and out_ready in HOLD: the output is taken and state goes to IDLE.
//    in_ready is 0 on that edge, so the input is accepted on a later IDLE cycle.
// TESTING
//  1. Accept gray_in=0101 -> 4 clocks later out_valid=1, bin_out=0110, adj_err=0.
//  2. Stream 0000,0001,0011,0010 (out_ready=1) -> bin_out 0000,0001,0010,0011, adj_err=0 each.
//  3. 0000 then 0011 -> second result bin_out=0010 with adj_err=1. Next word 0011 -> adj_err=0.
//  4. Wrap: 1000 then 0000 -> bin_out 1111 then 0000, adj_err=0 both.
//  5. Hold out_ready=0 for 5 clocks in HOLD -> out_valid, bin_out, adj_err stable; in_ready=0.
//     Then out_ready=1 -> next clock out_valid=0, in_ready=1.
//  6. Drop rst_n for 1 clock mid-DECODE -> all outputs 0. Next word 0110 gives bin_out=0100 with adj_err=0.

Source files
------------

// File: rtl/gray_decoder_serial.sv
// Serial Gray-to-binary decoder. Accepts one Gray word over a valid/ready
// handshake, decodes it MSB-first one bit per clock with a running XOR, and
// presents the binary result (plus an adjacency flag) over a second
// valid/ready handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and data
// stable until that edge; ready may depend on state but never on valid.
module gray_decoder_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             adj_err
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] prev_gray;
  logic             prev_valid;
  logic [IW-1:0]    idx;
  logic             acc;
  logic             cur_bit;
  logic             accept;

  // True when the two words differ in more than one bit position.
  function automatic logic multi_bit_diff(input logic [WIDTH-1:0] d);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) n++;
    end
    return (n > 1);
  endfunction

  // Next-state and handshake outputs; in_ready is forced low during reset.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        accept   = in_valid && rst_n;
        if (accept) state_next = DECODE;
      end
      DECODE: begin
        if (idx == '0) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current decoded bit: XOR of all Gray bits from the MSB down to idx.
  always_comb begin
    cur_bit = acc ^ g_reg[idx];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: capture on accept, shift out one decoded bit per DECODE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_reg      <= '0;
      prev_gray  <= '0;
      prev_valid <= 1'b0;
      idx        <= '0;
      acc        <= 1'b0;
      bin_out    <= '0;
      adj_err    <= 1'b0;
    end else if (accept) begin
      g_reg      <= gray_in;
      prev_gray  <= gray_in;
      prev_valid <= 1'b1;
      idx        <= IW'(WIDTH - 1);
      acc        <= 1'b0;
      bin_out    <= '0;
      adj_err    <= prev_valid && multi_bit_diff(gray_in ^ prev_gray);
    end else if (state == DECODE) begin
      bin_out[idx] <= cur_bit;
      acc          <= cur_bit;
      idx          <= idx - 1'b1;
    end
  end

endmodule
